bridge_fc_scheduler: RTL and testbench
======================================

# bridge_fc_scheduler

Transmit flow-credit scheduler for the PCIe bridge. It repeatedly polls the core's transmit-available flow credits via the fc_sel interface and latches the six credit counts. It then arbitrates among the posted, non-posted and completion requesters of the Tx bridge, granting a TLP slot only when the latest credits cover that TLP. It sits between bridge control (ready/reset) and the Tx bridge.

## Interface

- FC_WAIT, 1: cycles spent in WAIT1 between issuing fc_sel and latching credits (1..7).
- Sched_CLK  in  1  clock; all logic synchronous to its rising edge.
- Sched_RST  in  1  reset, asynchronous, active-low.
- Sched_Ready  in  1  bridge ready (link up, out of reset); low forces IDLE.
- Sched_fc_ph, Sched_fc_nph, Sched_fc_cplh  in  8 each  header credits from core.
- Sched_fc_pd, Sched_fc_npd, Sched_fc_cpld  in  12 each  data credits from core (1 credit = 4 DW).
- Sched_Req  in  3  request; bit 0 posted, 1 non-posted, 2 completion.
- Sched_Len  in  30  payload length in DW, 10 bits per requester ([9:0] posted, ...); 0 means 1024.
- Sched_Has_Data  in  3  per requester: TLP carries payload.
- Sched_Done  in  1  Tx bridge finished the granted TLP.
- Sched_fc_sel  out  3  flow-control select to core.
- Sched_Gnt  out  3  one-hot grant.
- Sched_Fc_Valid  out  1  credits latched at least once since reset/Ready rise.
- Sched_Stall  out  3  requester pending but blocked by credits at last ARB.

## Operation

- States: IDLE, REQ_FC, WAIT1, STR_FC, ARB, GNT.
- IDLE: Sched_Ready=1 -> REQ_FC.
- REQ_FC: drive fc_sel=3'b100 (TXAVAIL). fc_sel is constant 3'b100 in all states. -> WAIT1.
- WAIT1: stay FC_WAIT cycles using a 3-bit counter, then -> STR_FC.
- STR_FC: latch all six credit inputs into shadow registers; set Fc_Valid=1. -> ARB.
- ARB: evaluate eligibility of each requester i against the shadow credits.
  - need_d = Has_Data[i] ? (len==0 ? 256 : (len+3)>>2) : 0. Width: 11 bits, compared zero-extended to 12.
  - Eligible when Req[i]=1, header credit >= 1, and data credit >= need_d.
  - Choose the first eligible requester in round-robin order ptr, ptr+1, ptr+2 (mod 3).
  - Stall[i] = Req[i] & ~eligible[i], registered in ARB and held until the next ARB.
  - If a requester is chosen: Gnt = onehot(i), ptr = (i+1) mod 3, -> GNT.
  - If none is chosen: -> REQ_FC (continuous polling).
- GNT: hold Gnt.
  - Done=1, or Req[granted]=0 (abort): clear Gnt, -> REQ_FC. Credits are always re-polled before the next grant.
  - Done while not in GNT is ignored.
- Sched_Ready=0 in any state: next state IDLE, Gnt=0, Fc_Valid=0, Stall=0. Shadow credits and ptr are kept.
- Shadow credits are never decremented locally; the core's report is authoritative.

## Timing

- Reset values: state IDLE, Sched_fc_sel=3'b100, Gnt=0, Fc_Valid=0, Stall=0, ptr=0, shadow credits 0, wait counter 0.
- All outputs are registered.
- Credit sample point: the inputs present on the clock edge that leaves STR_FC.
- Latency with FC_WAIT=1, counted from the edge entering REQ_FC: Gnt asserts 4 edges later (REQ, WAIT1, STR, ARB).
- Gnt drops on the edge after Done is sampled high. The next grant is possible 4 edges after that.
- Simultaneous Done and Ready=0: go to IDLE; ptr is already advanced.
- Reset asserted mid-GNT: Gnt is cleared asynchronously, with no Done required.

## Test plan

- Reset/idle: hold Ready=0 for 10 cycles -> Gnt=0, Fc_Valid=0, fc_sel=3'b100 throughout; release Ready -> Fc_Valid=1 on the 3rd edge.
- Single grant: ph=1, pd=4, Req=001, Len[9:0]=16, Has_Data=1 -> Gnt=001 on the 4th edge; Done pulse -> Gnt=0 on the next edge.
- Credit block: pd=3, Len=13 (need 4) -> Stall=001, no grant. Raise pd to 4 -> grant within 5 cycles.
- Round robin: all Req=111, all credits large, Done each grant -> grant order 001, 010, 100, 001.
- Length 0 and no data: Len=0 with Has_Data=1 requires pd>=256 (pd=255 stalls); non-posted read with Has_Data=0 and npd=0, nph=1 -> granted.
- Abort/reset: drop Req[granted] in GNT -> Gnt=0 next edge, state REQ_FC. Assert Sched_RST low mid-GNT -> Gnt=0 immediately.

Source files
------------

// File: rtl/bridge_fc_scheduler.sv
// Purpose: polls core Tx-available flow credits and grants one of posted/non-posted/completion TLP slots when the latest credits cover it.
// Latency: with FC_WAIT=1 the grant appears 4 edges after entering REQ_FC (REQ, WAIT1, STR, ARB); all outputs registered.
// Backpressure: a requester blocked by credits is flagged in Sched_Stall and re-evaluated after every fresh credit poll; Gnt holds until Done or abort.
module bridge_fc_scheduler #(
  parameter int unsigned FC_WAIT = 1
) (
  input  logic        Sched_CLK,
  input  logic        Sched_RST,
  input  logic        Sched_Ready,
  input  logic [7:0]  Sched_fc_ph,
  input  logic [7:0]  Sched_fc_nph,
  input  logic [7:0]  Sched_fc_cplh,
  input  logic [11:0] Sched_fc_pd,
  input  logic [11:0] Sched_fc_npd,
  input  logic [11:0] Sched_fc_cpld,
  input  logic [2:0]  Sched_Req,
  input  logic [29:0] Sched_Len,
  input  logic [2:0]  Sched_Has_Data,
  input  logic        Sched_Done,
  output logic [2:0]  Sched_fc_sel,
  output logic [2:0]  Sched_Gnt,
  output logic        Sched_Fc_Valid,
  output logic [2:0]  Sched_Stall
);

  typedef enum logic [2:0] {IDLE, REQ_FC, WAIT1, STR_FC, ARB, GNT} state_t;

  localparam logic [2:0] FC_SEL_TXAVAIL = 3'b100;
  localparam logic [2:0] WAIT_LAST      = 3'(FC_WAIT - 1);

  state_t      state, state_nxt;
  logic [2:0]  gnt_q, gnt_nxt;
  logic        fcv_q, fcv_nxt;
  logic [2:0]  stall_q, stall_nxt;
  logic [1:0]  ptr_q, ptr_nxt;
  logic [2:0]  cnt_q, cnt_nxt;
  logic        latch_en;

  // shadow credits, index 0 posted, 1 non-posted, 2 completion
  logic [7:0]  hdr_cred [3];
  logic [11:0] dat_cred [3];

  logic [10:0] need_d [3];
  logic [2:0]  elig;
  logic        pick_vld;
  logic [1:0]  pick_idx;

  // reduce a small sum modulo 3 (inputs never exceed 4)
  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  // the core's credit-select is fixed at Tx-available
  assign Sched_fc_sel   = FC_SEL_TXAVAIL;
  assign Sched_Gnt      = gnt_q;
  assign Sched_Fc_Valid = fcv_q;
  assign Sched_Stall    = stall_q;

  // per-requester data need (4 DW per credit, length 0 is 1024 DW) and eligibility against shadow credits
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      need_d[i] = 11'd0;
      if (Sched_Has_Data[i]) begin
        if (Sched_Len[i*10 +: 10] == 10'd0) need_d[i] = 11'd256;
        else                                need_d[i] = ({1'b0, Sched_Len[i*10 +: 10]} + 11'd3) >> 2;
      end
      elig[i] = Sched_Req[i] && (hdr_cred[i] != 8'd0) && (dat_cred[i] >= {1'b0, need_d[i]});
    end
  end

  // round-robin pick: first eligible requester starting at ptr
  always_comb begin
    logic [1:0] idx;
    pick_vld = 1'b0;
    pick_idx = 2'd0;
    for (int k = 0; k < 3; k++) begin
      idx = wrap3({1'b0, ptr_q} + 3'(k));
      if (!pick_vld && elig[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx;
      end
    end
  end

  // next-state and next-output logic; bridge not ready overrides everything except ptr and shadow credits
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    fcv_nxt   = fcv_q;
    stall_nxt = stall_q;
    ptr_nxt   = ptr_q;
    cnt_nxt   = 3'd0;
    latch_en  = 1'b0;
    case (state)
      IDLE:   if (Sched_Ready) state_nxt = REQ_FC;
      REQ_FC: state_nxt = WAIT1;
      WAIT1: begin
        if (cnt_q == WAIT_LAST) state_nxt = STR_FC;
        else                    cnt_nxt   = cnt_q + 3'd1;
      end
      STR_FC: begin
        latch_en  = 1'b1;
        fcv_nxt   = 1'b1;
        state_nxt = ARB;
      end
      ARB: begin
        stall_nxt = Sched_Req & ~elig;
        if (pick_vld) begin
          gnt_nxt   = 3'b001 << pick_idx;
          ptr_nxt   = wrap3({1'b0, pick_idx} + 3'd1);
          state_nxt = GNT;
        end else begin
          state_nxt = REQ_FC;
        end
      end
      GNT: begin
        // completion or requester withdrawal both end the slot; credits are re-polled first
        if (Sched_Done || ((Sched_Req & gnt_q) == 3'b000)) begin
          gnt_nxt   = 3'b000;
          state_nxt = REQ_FC;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!Sched_Ready) begin
      state_nxt = IDLE;
      gnt_nxt   = 3'b000;
      fcv_nxt   = 1'b0;
      stall_nxt = 3'b000;
      ptr_nxt   = ptr_q;
      cnt_nxt   = 3'd0;
      latch_en  = 1'b0;
    end
  end

  // state and registered outputs
  always_ff @(posedge Sched_CLK or negedge Sched_RST) begin
    if (!Sched_RST) begin
      state   <= IDLE;
      gnt_q   <= 3'b000;
      fcv_q   <= 1'b0;
      stall_q <= 3'b000;
      ptr_q   <= 2'd0;
      cnt_q   <= 3'd0;
    end else begin
      state   <= state_nxt;
      gnt_q   <= gnt_nxt;
      fcv_q   <= fcv_nxt;
      stall_q <= stall_nxt;
      ptr_q   <= ptr_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // shadow credit capture on the edge leaving STR_FC; never decremented locally
  always_ff @(posedge Sched_CLK or negedge Sched_RST) begin
    if (!Sched_RST) begin
      for (int i = 0; i < 3; i++) begin
        hdr_cred[i] <= 8'd0;
        dat_cred[i] <= 12'd0;
      end
    end else if (latch_en) begin
      hdr_cred[0] <= Sched_fc_ph;
      hdr_cred[1] <= Sched_fc_nph;
      hdr_cred[2] <= Sched_fc_cplh;
      dat_cred[0] <= Sched_fc_pd;
      dat_cred[1] <= Sched_fc_npd;
      dat_cred[2] <= Sched_fc_cpld;
    end
  end

endmodule

// File: tb/tb_bridge_fc_scheduler.sv
// Purpose: checks bridge_fc_scheduler against a timeline model of the credit-poll/arbitrate loop plus hand-computed pins.
// Latency: model advances once per rising edge; outputs compared on every falling edge while out of reset.
// Backpressure: Done/Req withdrawal and Ready drops are randomized alongside credit and length changes.
module tb_bridge_fc_scheduler;

  localparam int FC_WAIT = 1;

  logic        clk;
  logic        rst_n;
  logic        ready;
  logic [7:0]  ph, nph, cplh;
  logic [11:0] pd, npd, cpld;
  logic [2:0]  req;
  logic [29:0] len;
  logic [2:0]  has_data;
  logic        done;
  logic [2:0]  fc_sel;
  logic [2:0]  gnt;
  logic        fc_valid;
  logic [2:0]  stall;

  int n_chk;
  int n_err;

  bridge_fc_scheduler #(.FC_WAIT(FC_WAIT)) dut (
    .Sched_CLK      (clk),
    .Sched_RST      (rst_n),
    .Sched_Ready    (ready),
    .Sched_fc_ph    (ph),
    .Sched_fc_nph   (nph),
    .Sched_fc_cplh  (cplh),
    .Sched_fc_pd    (pd),
    .Sched_fc_npd   (npd),
    .Sched_fc_cpld  (cpld),
    .Sched_Req      (req),
    .Sched_Len      (len),
    .Sched_Has_Data (has_data),
    .Sched_Done     (done),
    .Sched_fc_sel   (fc_sel),
    .Sched_Gnt      (gnt),
    .Sched_Fc_Valid (fc_valid),
    .Sched_Stall    (stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_t counts edges since the current credit poll began; credits are
  // captured FC_WAIT+2 edges in and the decision is made one edge later.
  bit       m_up;
  int       m_t;
  int       m_g;      // granted requester, -1 when none
  int       m_ptr;
  bit       m_fcv;
  bit [2:0] m_stall;
  int       m_h [3];
  int       m_d [3];

  function automatic int need_credits(input bit hd, input int l);
    if (!hd)    return 0;
    if (l == 0) return 256;
    return (l + 3) / 4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_up = 0; m_t = 0; m_g = -1; m_ptr = 0; m_fcv = 0; m_stall = 3'b000;
      for (int i = 0; i < 3; i++) begin m_h[i] = 0; m_d[i] = 0; end
    end else if (!ready) begin
      m_up = 0; m_g = -1; m_fcv = 0; m_stall = 3'b000;
    end else if (!m_up) begin
      m_up = 1; m_t = 0;
    end else if (m_g >= 0) begin
      if (done || !req[m_g]) begin m_g = -1; m_t = 0; end
    end else begin
      m_t++;
      if (m_t == FC_WAIT + 2) begin
        m_h[0] = int'(ph);  m_h[1] = int'(nph); m_h[2] = int'(cplh);
        m_d[0] = int'(pd);  m_d[1] = int'(npd); m_d[2] = int'(cpld);
        m_fcv = 1;
      end else if (m_t == FC_WAIT + 3) begin
        int chosen;
        chosen  = -1;
        m_stall = 3'b000;
        for (int k = 0; k < 3; k++) begin
          int  i;
          bit  ok;
          i  = (m_ptr + k) % 3;
          ok = req[i] && (m_h[i] > 0) &&
               (m_d[i] >= need_credits(has_data[i], int'(len[i*10 +: 10])));
          if (req[i] && !ok) m_stall[i] = 1'b1;
          if (ok && chosen < 0) chosen = i;
        end
        if (chosen >= 0) begin
          m_g   = chosen;
          m_ptr = (chosen + 1) % 3;
        end else begin
          m_t = 0;
        end
      end
    end
  end

  // compare DUT against the model on every falling edge out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      check("model_gnt",   32'(gnt),      (m_g < 0) ? 32'd0 : (32'd1 << m_g));
      check("model_fcv",   32'(fc_valid), 32'(m_fcv));
      check("model_stall", 32'(stall),    32'(m_stall));
      check("model_fcsel", 32'(fc_sel),   32'd4);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_gnt(input int max_cyc, input logic [2:0] exp, input string nm);
    int n;
    n = 0;
    while (gnt === 3'b000 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(gnt), 32'(exp));
  endtask

  task automatic pulse_done(input string nm);
    done = 1'b1;
    @(negedge clk);
    check(nm, 32'(gnt), 32'd0);
    done = 1'b0;
  endtask

  task automatic set_credits(input int h, input int d);
    ph = 8'(h); nph = 8'(h); cplh = 8'(h);
    pd = 12'(d); npd = 12'(d); cpld = 12'(d);
  endtask

  logic [2:0] rr_exp [4];

  initial begin
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; ready = 1'b0; done = 1'b0;
    req = 3'b000; len = 30'd0; has_data = 3'b000;
    set_credits(0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_gnt",   32'(gnt),      32'd0);
    check("rst_fcv",   32'(fc_valid), 32'd0);
    check("rst_stall", 32'(stall),    32'd0);
    check("rst_fcsel", 32'(fc_sel),   32'd4);

    // Ready low keeps everything idle
    repeat (10) begin
      @(negedge clk);
      check("idle_gnt", 32'(gnt),      32'd0);
      check("idle_fcv", 32'(fc_valid), 32'd0);
    end

    // single grant: ph=1 pd=4, posted 16 DW
    ph = 8'd1; pd = 12'd4; req = 3'b001; len[9:0] = 10'd16; has_data = 3'b001;
    ready = 1'b1;
    @(negedge clk);                 // edge entering REQ_FC
    repeat (2) @(negedge clk);
    check("fcv_before", 32'(fc_valid), 32'd0);
    @(negedge clk);                 // 3rd edge after REQ_FC
    check("fcv_3rd", 32'(fc_valid), 32'd1);
    check("gnt_3rd", 32'(gnt),      32'd0);
    @(negedge clk);                 // 4th edge
    check("gnt_4th", 32'(gnt), 32'd1);
    pulse_done("done_drop");

    // credit block: 13 DW needs 4 credits, only 3 available
    len[9:0] = 10'd13; pd = 12'd3;
    repeat (10) @(negedge clk);
    check("blk_stall", 32'(stall), 32'd1);
    check("blk_gnt",   32'(gnt),   32'd0);
    pd = 12'd4;
    wait_gnt(5, 3'b001, "blk_release");
    pulse_done("blk_done");

    // round robin from a fresh pointer
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_credits(10, 1000);
    req = 3'b111; has_data = 3'b000;
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(10, rr_exp[k], "rr_order");
      pulse_done("rr_done");
    end

    // length 0 means 1024 DW -> 256 credits
    set_credits(0, 0);
    req = 3'b001; has_data = 3'b001; len = 30'd0; ph = 8'd1; pd = 12'd255;
    repeat (10) @(negedge clk);
    check("len0_stall", 32'(stall), 32'd1);
    check("len0_gnt",   32'(gnt),   32'd0);
    pd = 12'd256;
    wait_gnt(5, 3'b001, "len0_grant");
    pulse_done("len0_done");

    // non-posted read needs no data credit
    set_credits(0, 0);
    req = 3'b010; has_data = 3'b000; nph = 8'd1;
    wait_gnt(10, 3'b010, "np_read");

    // abort by withdrawing the request, then an exact re-grant 4 edges after REQ_FC
    req = 3'b000;
    @(negedge clk);
    check("abort_gnt", 32'(gnt), 32'd0);
    req = 3'b010;
    repeat (3) begin
      @(negedge clk);
      check("abort_regnt_wait", 32'(gnt), 32'd0);
    end
    @(negedge clk);
    check("abort_regnt", 32'(gnt), 32'd2);

    // asynchronous reset during GNT
    #2 rst_n = 1'b0;
    #1 check("arst_gnt", 32'(gnt), 32'd0);
    check("arst_fcv", 32'(fc_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      ready = ($urandom_range(0, 63) != 0);
      done  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) req = 3'($urandom);
      if ($urandom_range(0, 7) == 0) has_data = 3'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < 3; i++) begin
          case ($urandom_range(0, 3))
            0:       len[i*10 +: 10] = 10'd0;
            1:       len[i*10 +: 10] = 10'($urandom_range(1, 40));
            default: len[i*10 +: 10] = 10'($urandom);
          endcase
        end
      end
      if ($urandom_range(0, 7) == 0) begin
        ph   = 8'($urandom_range(0, 2));
        nph  = 8'($urandom_range(0, 2));
        cplh = 8'($urandom_range(0, 2));
        pd   = 12'($urandom_range(0, 300));
        npd  = 12'($urandom_range(0, 300));
        cpld = 12'($urandom_range(0, 300));
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
